// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, M-extension funct3 codes and FSM state encodings for the
// execute-stage ALU with iterative multiply/divide.
package alu_muldiv_pkg;

  // Base ALU op codes
  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpSubu  = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpXor   = 4'd5;
  localparam logic [3:0] OpSll   = 4'd6;
  localparam logic [3:0] OpSrl   = 4'd7;
  localparam logic [3:0] OpSra   = 4'd8;
  localparam logic [3:0] OpSlt   = 4'd9;
  localparam logic [3:0] OpSltu  = 4'd10;
  localparam logic [3:0] OpLui   = 4'd11;
  localparam logic [3:0] OpAuipc = 4'd12;

  // RV32M funct3
  localparam logic [2:0] MduMul    = 3'b000;
  localparam logic [2:0] MduMulh   = 3'b001;
  localparam logic [2:0] MduMulhsu = 3'b010;
  localparam logic [2:0] MduMulhu  = 3'b011;
  localparam logic [2:0] MduDiv    = 3'b100;
  localparam logic [2:0] MduDivu   = 3'b101;
  localparam logic [2:0] MduRem    = 3'b110;
  localparam logic [2:0] MduRemu   = 3'b111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic ModeMul = 1'b0;
  localparam logic ModeDiv = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// {hi,lo} is the product register (mul) or {remainder,quotient} (div).
module alu_muldiv_iter_step
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         mode,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] d,
  output logic [N-1:0] hi_nxt,
  output logic [N-1:0] lo_nxt
);

  logic [N:0] sum;
  logic [N:0] shl;
  logic [N:0] diff;

  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
    shl  = {hi, lo[N-1]};
    // remainder < divisor keeps diff within N+1 bits, so bit N is the borrow
    diff = shl - {1'b0, d};
    if (mode == ModeDiv) begin
      if (!diff[N]) begin
        hi_nxt = diff[N-1:0];
        lo_nxt = {lo[N-2:0], 1'b1};
      end else begin
        hi_nxt = shl[N-1:0];
        lo_nxt = {lo[N-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[N:1];
      lo_nxt = {sum[0], lo[N-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle base ops plus iterative RV32M multiply/divide,
// valid/ready on both sides and a synchronous flush.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic [3:0]   op,
  input  logic         m_en,
  input  logic [2:0]   m_funct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         zero,
  output logic         overflow
);

  localparam int unsigned CNT_W = $clog2(N) + 1;
  localparam int unsigned SHW   = $clog2(N);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(N);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     hi_q, hi_d, lo_q, lo_d, d_q, d_d;
  logic             fneg_q, fneg_d, rneg_q, rneg_d;
  logic [1:0]       funct_q, funct_d;
  logic [N-1:0]     out_q, out_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;

  logic             accept, load;
  logic             signed_a, signed_b, sa, sb;
  logic [N-1:0]     mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [N-1:0]     special_res;
  logic [N:0]       sum_ab, dif_ab, sum_pc;
  logic [N-1:0]     upper_b, base_res;
  logic             base_ovf;
  logic [SHW-1:0]   shamt;
  logic             step_mode;
  logic [N-1:0]     step_hi, step_lo, step_d, step_hi_nxt, step_lo_nxt;
  logic [2*N-1:0]   prod, prod_fix;
  logic [N-1:0]     q_fix, r_fix, fix_res;

  assign in_ready  = !flush & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign out       = out_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

  // Operand signedness from funct3: bit 2 selects divide, bit 0 marks unsigned divide
  assign signed_a = m_funct[2] ? !m_funct[0] : (m_funct[1:0] != 2'b11);
  assign signed_b = m_funct[2] ? !m_funct[0] : !m_funct[1];
  assign sa       = signed_a & inA[N-1];
  assign sb       = signed_b & inB[N-1];
  assign mag_a    = sa ? -inA : inA;
  assign mag_b    = sb ? -inB : inB;

  assign div_zero    = (inB == '0);
  assign div_ovf     = !m_funct[0] & (inA == {1'b1, {(N-1){1'b0}}}) & (inB == '1);
  assign special     = m_funct[2] & (div_zero | div_ovf);
  assign special_res = div_zero ? (m_funct[1] ? inA : '1) : (m_funct[1] ? '0 : inA);

  assign sum_ab  = {1'b0, inA} + {1'b0, inB};
  assign dif_ab  = {1'b0, inA} - {1'b0, inB};
  assign upper_b = {inB[N-1:12], 12'b0};
  assign sum_pc  = {1'b0, inA} + {1'b0, upper_b};
  assign shamt   = inB[SHW-1:0];

  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    case (op)
      OpAdd:   begin base_res = sum_ab[N-1:0]; base_ovf = sum_ab[N]; end
      OpSub:   begin base_res = dif_ab[N-1:0]; base_ovf = dif_ab[N]; end
      OpSubu:  base_res = dif_ab[N:1];
      OpAnd:   base_res = inA & inB;
      OpOr:    base_res = inA | inB;
      OpXor:   base_res = inA ^ inB;
      OpSll:   base_res = inA << shamt;
      OpSrl:   base_res = inA >> shamt;
      OpSra:   base_res = $signed(inA) >>> shamt;
      OpSlt:   base_res = {{(N-1){1'b0}}, $signed(inA) < $signed(inB)};
      OpSltu:  base_res = {{(N-1){1'b0}}, inA < inB};
      OpLui:   base_res = upper_b;
      OpAuipc: begin base_res = sum_pc[N-1:0]; base_ovf = sum_pc[N]; end
      default: ;
    endcase
  end

  // The first iteration runs on the incoming operands during the accept cycle
  always_comb begin
    if ((state_q == StMul) || (state_q == StDiv)) begin
      step_mode = (state_q == StDiv) ? ModeDiv : ModeMul;
      step_hi   = hi_q;
      step_lo   = lo_q;
      step_d    = d_q;
    end else begin
      step_mode = m_funct[2] ? ModeDiv : ModeMul;
      step_hi   = '0;
      step_lo   = m_funct[2] ? mag_a : mag_b;
      step_d    = m_funct[2] ? mag_b : mag_a;
    end
  end

  alu_muldiv_iter_step #(
    .N(N)
  ) u_step (
    .mode   (step_mode),
    .hi     (step_hi),
    .lo     (step_lo),
    .d      (step_d),
    .hi_nxt (step_hi_nxt),
    .lo_nxt (step_lo_nxt)
  );

  assign prod     = {hi_q, lo_q};
  assign prod_fix = fneg_q ? -prod : prod;
  assign q_fix    = fneg_q ? -lo_q : lo_q;
  assign r_fix    = rneg_q ? -hi_q : hi_q;

  always_comb begin
    if (state_q == StDiv) begin
      fix_res = funct_q[1] ? r_fix : q_fix;
    end else begin
      fix_res = (funct_q == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    fneg_d  = fneg_q;
    rneg_d  = rneg_q;
    funct_d = funct_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    load    = 1'b0;

    case (state_q)
      StIdle: load = accept;
      StMul, StDiv: begin
        if (cnt_q == CntMax) begin
          out_d   = fix_res;
          zero_d  = (fix_res == '0);
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          hi_d  = step_hi_nxt;
          lo_d  = step_lo_nxt;
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          load    = accept;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (!m_en) begin
        out_d   = base_res;
        zero_d  = (base_res == '0);
        ovf_d   = base_ovf;
        state_d = StDone;
      end else if (special) begin
        out_d   = special_res;
        zero_d  = (special_res == '0);
        ovf_d   = !div_zero & div_ovf;
        state_d = StDone;
      end else begin
        hi_d    = step_hi_nxt;
        lo_d    = step_lo_nxt;
        d_d     = step_d;
        fneg_d  = sa ^ sb;
        rneg_d  = sa;
        funct_d = m_funct[1:0];
        cnt_d   = CntOne;
        state_d = m_funct[2] ? StDiv : StMul;
      end
    end

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      fneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      funct_q <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      fneg_q  <= fneg_d;
      rneg_q  <= rneg_d;
      funct_q <= funct_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
